// File: rtl/wb_fwd_rv32i_pkg.sv
// Shared definitions for the rv32i writeback / forwarding-source stage.
// Holds the register/data widths, the x0 register constant and the
// load-tracking state encoding used by wb_fwd_rv32i.
package wb_fwd_rv32i_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] X0 = 5'd0;

    // IDLE: no load outstanding. WAIT: one load issued, response pending.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } ld_state_t;
endpackage

// File: rtl/wb_fwd_rv32i_slot.sv
// wb_slot: one pipeline holding register (valid, rd, data, load flag).
// Ports:
//   CLK, RST       clock and synchronous active-high reset
//   clr            invalidate the slot (wins over ld)
//   ld             capture the src_* fields
//   src_*          incoming contents
//   slot_*         current contents
// With neither clr nor ld asserted the slot holds its contents.
module wb_slot
    import wb_fwd_rv32i_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              clr,
    input  logic              ld,
    input  logic              src_valid,
    input  logic [REG_AW-1:0] src_rd,
    input  logic [XLEN-1:0]   src_data,
    input  logic              src_load,
    output logic              slot_valid,
    output logic [REG_AW-1:0] slot_rd,
    output logic [XLEN-1:0]   slot_data,
    output logic              slot_load
);
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            slot_valid <= 1'b0;
            slot_rd    <= X0;
            slot_data  <= '0;
            slot_load  <= 1'b0;
        end else if (ld) begin
            slot_valid <= src_valid;
            slot_rd    <= src_rd;
            slot_data  <= src_data;
            slot_load  <= src_load;
        end
    end
endmodule

// File: rtl/wb_fwd_rv32i.sv
// wb_fwd_rv32i: writeback and forwarding-source stage of the rv32i pipeline.
// Results enter the exec slot (E), age through the cushion slot (C) and are
// written to the register file through the single registered WADDR/WDATA
// port. One outstanding load is tracked; its memory response takes the
// write port ahead of C, and younger results to the same rd are held back.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   FLUSH                          kill E and C (pending load survives)
//   MEM_WAIT                       freeze E/C advance
//   EXEC_VALID/READY/RD/DATA/LOAD  execution result handshake
//   MEMR_VALID/DATA                load response
//   WADDR/WDATA                    register-file write port (WADDR 0 = none)
//   FWD_REG_ADDR                   rd of outstanding load, 0 when none
//   FWD_EXEC_*/FWD_CUSHION_*       forwarding views of E and C
module wb_fwd_rv32i
    import wb_fwd_rv32i_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              MEM_WAIT,
    input  logic              EXEC_VALID,
    output logic              EXEC_READY,
    input  logic [REG_AW-1:0] EXEC_RD,
    input  logic [XLEN-1:0]   EXEC_DATA,
    input  logic              EXEC_LOAD,
    input  logic              MEMR_VALID,
    input  logic [XLEN-1:0]   MEMR_DATA,
    output logic [REG_AW-1:0] WADDR,
    output logic [XLEN-1:0]   WDATA,
    output logic [REG_AW-1:0] FWD_REG_ADDR,
    output logic              FWD_EXEC_EN,
    output logic [REG_AW-1:0] FWD_EXEC_ADDR,
    output logic [XLEN-1:0]   FWD_EXEC_DATA,
    output logic              FWD_CUSHION_EN,
    output logic [REG_AW-1:0] FWD_CUSHION_ADDR,
    output logic [XLEN-1:0]   FWD_CUSHION_DATA
);
    ld_state_t         state_reg;
    logic [REG_AW-1:0] ld_rd_reg;
    logic [REG_AW-1:0] waddr_reg;
    logic [XLEN-1:0]   wdata_reg;

    logic              e_valid, e_load, c_valid, c_load;
    logic [REG_AW-1:0] e_rd, c_rd;
    logic [XLEN-1:0]   e_data, c_data;

    logic wait_st, conflict, waw, block2, advance;
    logic ld_resp, ld_issue, c_commit;

    assign wait_st  = (state_reg == ST_WAIT);
    // Load response and C both want the write port: C yields.
    assign conflict = wait_st && MEMR_VALID && c_valid;
    // A younger result to the pending load's rd must not overtake the load.
    assign waw      = wait_st && e_valid && (e_rd != X0) && (e_rd == ld_rd_reg);
    // Only one load may be outstanding.
    assign block2   = wait_st && e_valid && e_load;
    assign advance  = !MEM_WAIT && !conflict && !waw && !block2;

    assign ld_resp  = wait_st && MEMR_VALID;
    // Killed slots neither issue a load nor commit.
    assign ld_issue = advance && !FLUSH && e_valid && e_load;
    assign c_commit = advance && !FLUSH && c_valid && !c_load;

    wb_slot u_slot_e (
        .CLK        (CLK),
        .RST        (RST),
        .clr        (FLUSH),
        .ld         (advance),
        .src_valid  (EXEC_VALID),
        .src_rd     (EXEC_RD),
        .src_data   (EXEC_DATA),
        .src_load   (EXEC_LOAD),
        .slot_valid (e_valid),
        .slot_rd    (e_rd),
        .slot_data  (e_data),
        .slot_load  (e_load)
    );

    // A load leaving E hands off to the FSM, so C receives a bubble.
    wb_slot u_slot_c (
        .CLK        (CLK),
        .RST        (RST),
        .clr        (FLUSH),
        .ld         (advance),
        .src_valid  (e_valid && !e_load),
        .src_rd     (e_rd),
        .src_data   (e_data),
        .src_load   (1'b0),
        .slot_valid (c_valid),
        .slot_rd    (c_rd),
        .slot_data  (c_data),
        .slot_load  (c_load)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            ld_rd_reg <= X0;
            waddr_reg <= X0;
            wdata_reg <= '0;
        end else begin
            waddr_reg <= X0;
            wdata_reg <= '0;
            if (ld_resp) begin
                waddr_reg <= ld_rd_reg;
                wdata_reg <= MEMR_DATA;
                state_reg <= ST_IDLE;
            end else if (c_commit) begin
                waddr_reg <= c_rd;
                wdata_reg <= c_data;
            end
            // Never coincides with ld_resp: a load in E while WAIT blocks advance.
            if (ld_issue) begin
                state_reg <= ST_WAIT;
                ld_rd_reg <= e_rd;
            end
        end
    end

    assign EXEC_READY       = advance;
    assign WADDR            = waddr_reg;
    assign WDATA            = wdata_reg;
    assign FWD_REG_ADDR     = wait_st ? ld_rd_reg : X0;
    assign FWD_EXEC_EN      = e_valid && !e_load;
    assign FWD_EXEC_ADDR    = e_valid ? e_rd : X0;
    assign FWD_EXEC_DATA    = e_data;
    assign FWD_CUSHION_EN   = c_valid;
    assign FWD_CUSHION_ADDR = c_valid ? c_rd : X0;
    assign FWD_CUSHION_DATA = c_data;
endmodule

// File: tb/tb_wb_fwd_rv32i.sv
// Directed self-checking bench for wb_fwd_rv32i. Inputs change 1 time unit
// after the rising edge; outputs are checked in that same quiet window.
module tb_wb_fwd_rv32i;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        FLUSH = 1'b0;
    logic        MEM_WAIT = 1'b0;
    logic        EXEC_VALID = 1'b0;
    logic        EXEC_READY;
    logic [4:0]  EXEC_RD = 5'd0;
    logic [31:0] EXEC_DATA = 32'd0;
    logic        EXEC_LOAD = 1'b0;
    logic        MEMR_VALID = 1'b0;
    logic [31:0] MEMR_DATA = 32'd0;
    logic [4:0]  WADDR;
    logic [31:0] WDATA;
    logic [4:0]  FWD_REG_ADDR;
    logic        FWD_EXEC_EN;
    logic [4:0]  FWD_EXEC_ADDR;
    logic [31:0] FWD_EXEC_DATA;
    logic        FWD_CUSHION_EN;
    logic [4:0]  FWD_CUSHION_ADDR;
    logic [31:0] FWD_CUSHION_DATA;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    wb_fwd_rv32i dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
        .EXEC_VALID(EXEC_VALID), .EXEC_READY(EXEC_READY), .EXEC_RD(EXEC_RD),
        .EXEC_DATA(EXEC_DATA), .EXEC_LOAD(EXEC_LOAD),
        .MEMR_VALID(MEMR_VALID), .MEMR_DATA(MEMR_DATA),
        .WADDR(WADDR), .WDATA(WDATA), .FWD_REG_ADDR(FWD_REG_ADDR),
        .FWD_EXEC_EN(FWD_EXEC_EN), .FWD_EXEC_ADDR(FWD_EXEC_ADDR),
        .FWD_EXEC_DATA(FWD_EXEC_DATA), .FWD_CUSHION_EN(FWD_CUSHION_EN),
        .FWD_CUSHION_ADDR(FWD_CUSHION_ADDR), .FWD_CUSHION_DATA(FWD_CUSHION_DATA)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic offer(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic ld);
        EXEC_VALID = v; EXEC_RD = rd; EXEC_DATA = d; EXEC_LOAD = ld;
    endtask

    task automatic test_reset();
        RST = 1'b1; step(); step(); RST = 1'b0;
        n_checks++; if (WADDR !== 5'd0 || WDATA !== 32'd0) begin n_fail++; $display("FAIL reset_wport: got %0d/%h want 0/0", WADDR, WDATA); end
        n_checks++; if (FWD_EXEC_EN !== 1'b0 || FWD_EXEC_ADDR !== 5'd0 || FWD_EXEC_DATA !== 32'd0) begin n_fail++; $display("FAIL reset_fwd_exec: got %b/%0d/%h want 0/0/0", FWD_EXEC_EN, FWD_EXEC_ADDR, FWD_EXEC_DATA); end
        n_checks++; if (FWD_CUSHION_EN !== 1'b0 || FWD_CUSHION_ADDR !== 5'd0 || FWD_CUSHION_DATA !== 32'd0) begin n_fail++; $display("FAIL reset_fwd_cush: got %b/%0d/%h want 0/0/0", FWD_CUSHION_EN, FWD_CUSHION_ADDR, FWD_CUSHION_DATA); end
        n_checks++; if (FWD_REG_ADDR !== 5'd0) begin n_fail++; $display("FAIL reset_fwd_reg: got %0d want 0", FWD_REG_ADDR); end
        n_checks++; if (EXEC_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", EXEC_READY); end
        MEM_WAIT = 1'b1; #1;
        n_checks++; if (EXEC_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready_memwait: got %b want 0", EXEC_READY); end
        MEM_WAIT = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_alu_back_to_back();
        offer(1'b1, 5'd1, 32'h11, 1'b0); step();          // cycle 1: E = rd1
        offer(1'b1, 5'd2, 32'h22, 1'b0);
        n_checks++; if (FWD_EXEC_EN !== 1'b1 || FWD_EXEC_ADDR !== 5'd1 || FWD_EXEC_DATA !== 32'h11) begin n_fail++; $display("FAIL alu_e1: got %b/%0d/%h want 1/1/11", FWD_EXEC_EN, FWD_EXEC_ADDR, FWD_EXEC_DATA); end
        step(); offer(1'b0, 5'd0, 32'd0, 1'b0);          // cycle 2: C = rd1
        n_checks++; if (FWD_CUSHION_EN !== 1'b1 || FWD_CUSHION_ADDR !== 5'd1 || FWD_CUSHION_DATA !== 32'h11) begin n_fail++; $display("FAIL alu_c1: got %b/%0d/%h want 1/1/11", FWD_CUSHION_EN, FWD_CUSHION_ADDR, FWD_CUSHION_DATA); end
        n_checks++; if (WADDR !== 5'd0) begin n_fail++; $display("FAIL alu_nowrite_c2: got %0d want 0", WADDR); end
        step();                                          // cycle 3
        n_checks++; if (WADDR !== 5'd1 || WDATA !== 32'h11) begin n_fail++; $display("FAIL alu_w1: got %0d/%h want 1/11", WADDR, WDATA); end
        step();                                          // cycle 4
        n_checks++; if (WADDR !== 5'd2 || WDATA !== 32'h22) begin n_fail++; $display("FAIL alu_w2: got %0d/%h want 2/22", WADDR, WDATA); end
        step();
        n_checks++; if (WADDR !== 5'd0 || WDATA !== 32'd0) begin n_fail++; $display("FAIL alu_idle: got %0d/%h want 0/0", WADDR, WDATA); end
        $display("test_alu_back_to_back done");
    endtask

    task automatic test_load();
        offer(1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1); step(); offer(1'b0, 5'd0, 32'd0, 1'b0);
        n_checks++; if (FWD_EXEC_ADDR !== 5'd5 || FWD_EXEC_EN !== 1'b0) begin n_fail++; $display("FAIL load_in_e: got addr %0d en %b want 5/0", FWD_EXEC_ADDR, FWD_EXEC_EN); end
        n_checks++; if (FWD_REG_ADDR !== 5'd0) begin n_fail++; $display("FAIL load_reg_pre: got %0d want 0", FWD_REG_ADDR); end
        step();
        n_checks++; if (FWD_REG_ADDR !== 5'd5 || FWD_CUSHION_EN !== 1'b0) begin n_fail++; $display("FAIL load_wait: got reg %0d cen %b want 5/0", FWD_REG_ADDR, FWD_CUSHION_EN); end
        MEMR_VALID = 1'b1; MEMR_DATA = 32'hCAFE0000; step(); MEMR_VALID = 1'b0;
        n_checks++; if (WADDR !== 5'd5 || WDATA !== 32'hCAFE0000) begin n_fail++; $display("FAIL load_write: got %0d/%h want 5/cafe0000", WADDR, WDATA); end
        n_checks++; if (FWD_REG_ADDR !== 5'd0) begin n_fail++; $display("FAIL load_reg_post: got %0d want 0", FWD_REG_ADDR); end
        step();
        n_checks++; if (WADDR !== 5'd0) begin n_fail++; $display("FAIL load_after: got %0d want 0", WADDR); end
        $display("test_load done");
    endtask

    task automatic test_conflict();
        offer(1'b1, 5'd4, 32'd0, 1'b1); step();            // E = load rd4
        offer(1'b1, 5'd3, 32'h33, 1'b0); step();           // WAIT ld4, E = rd3
        offer(1'b0, 5'd0, 32'd0, 1'b0); step();            // C = rd3
        MEMR_VALID = 1'b1; MEMR_DATA = 32'h44; #1;
        n_checks++; if (EXEC_READY !== 1'b0) begin n_fail++; $display("FAIL conflict_ready: got %b want 0", EXEC_READY); end
        step(); MEMR_VALID = 1'b0;
        n_checks++; if (WADDR !== 5'd4 || WDATA !== 32'h44) begin n_fail++; $display("FAIL conflict_load_first: got %0d/%h want 4/44", WADDR, WDATA); end
        n_checks++; if (EXEC_READY !== 1'b1 || FWD_CUSHION_ADDR !== 5'd3) begin n_fail++; $display("FAIL conflict_hold: got rdy %b c %0d want 1/3", EXEC_READY, FWD_CUSHION_ADDR); end
        step();
        n_checks++; if (WADDR !== 5'd3 || WDATA !== 32'h33) begin n_fail++; $display("FAIL conflict_alu_second: got %0d/%h want 3/33", WADDR, WDATA); end
        step();
        $display("test_conflict done");
    endtask

    task automatic test_waw();
        offer(1'b1, 5'd7, 32'd0, 1'b1); step();            // E = load rd7
        offer(1'b1, 5'd7, 32'h77, 1'b0); step();           // WAIT ld7, E = alu rd7
        offer(1'b0, 5'd0, 32'd0, 1'b0); #1;
        n_checks++; if (EXEC_READY !== 1'b0) begin n_fail++; $display("FAIL waw_ready_a: got %b want 0", EXEC_READY); end
        step();
        n_checks++; if (EXEC_READY !== 1'b0 || WADDR !== 5'd0 || FWD_EXEC_ADDR !== 5'd7) begin n_fail++; $display("FAIL waw_stall: got rdy %b w %0d e %0d want 0/0/7", EXEC_READY, WADDR, FWD_EXEC_ADDR); end
        MEMR_VALID = 1'b1; MEMR_DATA = 32'h700; step(); MEMR_VALID = 1'b0;
        n_checks++; if (WADDR !== 5'd7 || WDATA !== 32'h700) begin n_fail++; $display("FAIL waw_load: got %0d/%h want 7/700", WADDR, WDATA); end
        n_checks++; if (EXEC_READY !== 1'b1) begin n_fail++; $display("FAIL waw_release: got %b want 1", EXEC_READY); end
        step();
        n_checks++; if (WADDR !== 5'd0 || FWD_CUSHION_ADDR !== 5'd7) begin n_fail++; $display("FAIL waw_cush: got w %0d c %0d want 0/7", WADDR, FWD_CUSHION_ADDR); end
        step();
        n_checks++; if (WADDR !== 5'd7 || WDATA !== 32'h77) begin n_fail++; $display("FAIL waw_alu: got %0d/%h want 7/77", WADDR, WDATA); end
        step();
        $display("test_waw done");
    endtask

    task automatic test_second_load();
        offer(1'b1, 5'd8, 32'd0, 1'b1); step();
        offer(1'b1, 5'd9, 32'd0, 1'b1); step();            // WAIT ld8, E = load9
        offer(1'b0, 5'd0, 32'd0, 1'b0); #1;
        n_checks++; if (EXEC_READY !== 1'b0 || FWD_REG_ADDR !== 5'd8 || FWD_EXEC_ADDR !== 5'd9) begin n_fail++; $display("FAIL block2: got rdy %b reg %0d e %0d want 0/8/9", EXEC_READY, FWD_REG_ADDR, FWD_EXEC_ADDR); end
        step();
        MEMR_VALID = 1'b1; MEMR_DATA = 32'h88; step(); MEMR_VALID = 1'b0;
        n_checks++; if (WADDR !== 5'd8 || WDATA !== 32'h88) begin n_fail++; $display("FAIL block2_ld8: got %0d/%h want 8/88", WADDR, WDATA); end
        n_checks++; if (EXEC_READY !== 1'b1 || FWD_REG_ADDR !== 5'd0) begin n_fail++; $display("FAIL block2_idle: got rdy %b reg %0d want 1/0", EXEC_READY, FWD_REG_ADDR); end
        step();
        n_checks++; if (FWD_REG_ADDR !== 5'd9 || WADDR !== 5'd0) begin n_fail++; $display("FAIL block2_wait9: got reg %0d w %0d want 9/0", FWD_REG_ADDR, WADDR); end
        MEMR_VALID = 1'b1; MEMR_DATA = 32'h99; step(); MEMR_VALID = 1'b0;
        n_checks++; if (WADDR !== 5'd9 || WDATA !== 32'h99) begin n_fail++; $display("FAIL block2_ld9: got %0d/%h want 9/99", WADDR, WDATA); end
        MEMR_VALID = 1'b1; MEMR_DATA = 32'hDEAD; step(); MEMR_VALID = 1'b0;
        n_checks++; if (WADDR !== 5'd0 || WDATA !== 32'd0) begin n_fail++; $display("FAIL memr_idle: got %0d/%h want 0/0", WADDR, WDATA); end
        $display("test_second_load done");
    endtask

    task automatic test_flush();
        offer(1'b1, 5'd10, 32'd0, 1'b1); step();
        offer(1'b1, 5'd11, 32'hBB, 1'b0); step();          // WAIT ld10, E = rd11
        offer(1'b1, 5'd12, 32'hCC, 1'b0); step();          // C = rd11, E = rd12
        offer(1'b0, 5'd0, 32'd0, 1'b0);
        n_checks++; if (FWD_EXEC_EN !== 1'b1 || FWD_CUSHION_EN !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got %b/%b want 1/1", FWD_EXEC_EN, FWD_CUSHION_EN); end
        FLUSH = 1'b1; step(); FLUSH = 1'b0;
        n_checks++; if (FWD_EXEC_EN !== 1'b0 || FWD_CUSHION_EN !== 1'b0 || FWD_REG_ADDR !== 5'd10) begin n_fail++; $display("FAIL flush_post: got %b/%b reg %0d want 0/0/10", FWD_EXEC_EN, FWD_CUSHION_EN, FWD_REG_ADDR); end
        MEMR_VALID = 1'b1; MEMR_DATA = 32'hAA; step(); MEMR_VALID = 1'b0;
        n_checks++; if (WADDR !== 5'd10 || WDATA !== 32'hAA) begin n_fail++; $display("FAIL flush_load: got %0d/%h want 10/aa", WADDR, WDATA); end
        // FLUSH together with the load response
        offer(1'b1, 5'd13, 32'd0, 1'b1); step();
        offer(1'b1, 5'd14, 32'hEE, 1'b0); step();          // WAIT ld13, E = rd14
        offer(1'b0, 5'd0, 32'd0, 1'b0);
        FLUSH = 1'b1; MEMR_VALID = 1'b1; MEMR_DATA = 32'h1313; step();
        FLUSH = 1'b0; MEMR_VALID = 1'b0;
        n_checks++; if (WADDR !== 5'd13 || WDATA !== 32'h1313 || FWD_EXEC_EN !== 1'b0 || FWD_REG_ADDR !== 5'd0) begin n_fail++; $display("FAIL flush_memr: got %0d/%h en %b reg %0d want 13/1313/0/0", WADDR, WDATA, FWD_EXEC_EN, FWD_REG_ADDR); end
        step();
        n_checks++; if (WADDR !== 5'd0 || FWD_CUSHION_EN !== 1'b0) begin n_fail++; $display("FAIL flush_memr_after: got w %0d cen %b want 0/0", WADDR, FWD_CUSHION_EN); end
        $display("test_flush done");
    endtask

    task automatic test_rst_mid_wait();
        offer(1'b1, 5'd15, 32'd0, 1'b1); step();
        offer(1'b0, 5'd0, 32'd0, 1'b0); step();
        n_checks++; if (FWD_REG_ADDR !== 5'd15) begin n_fail++; $display("FAIL rst_pre: got %0d want 15", FWD_REG_ADDR); end
        RST = 1'b1; step(); RST = 1'b0;
        n_checks++; if (FWD_REG_ADDR !== 5'd0 || WADDR !== 5'd0 || WDATA !== 32'd0) begin n_fail++; $display("FAIL rst_post: got reg %0d w %0d/%h want 0/0/0", FWD_REG_ADDR, WADDR, WDATA); end
        MEMR_VALID = 1'b1; MEMR_DATA = 32'h5555; step(); MEMR_VALID = 1'b0;
        n_checks++; if (WADDR !== 5'd0 || WDATA !== 32'd0) begin n_fail++; $display("FAIL rst_memr_ignored: got %0d/%h want 0/0", WADDR, WDATA); end
        $display("test_rst_mid_wait done");
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_load();
        test_conflict();
        test_waw();
        test_second_load();
        test_flush();
        test_rst_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
